// File: rtl/dsp_dpram_if.sv
// One port of the DSP dual-port RAM: access strobe, byte-enabled write data
// and the read-return pair. The controller side uses the slave modport.
interface dsp_dpram_if #(
  parameter int DW = 16,
  parameter int AW = 11
);
  logic              en;
  logic              we;
  logic [DW/8-1:0]   be;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     din;
  logic [DW-1:0]     dout;
  logic              vld;

  modport master (output en, we, be, addr, din, input  dout, vld);
  modport slave  (input  en, we, be, addr, din, output dout, vld);
endinterface

// File: rtl/dsp_dpram_ctl.sv
// Parametrised single-clock true dual-port RAM with byte enables, selectable
// read-during-write behaviour, optional output register and a clear sequencer.

// Read-return pipeline for one port: 1 or 2 stages, data held between reads.
module dsp_dpram_rdport #(
  parameter int DW      = 16,
  parameter bit OUT_REG = 1
)(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rd,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_dout,
  output logic          o_vld
);
  localparam int STAGES = OUT_REG ? 2 : 1;

  logic [STAGES:1]         r_vld_pipe;
  logic [STAGES:1][DW-1:0] r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_pipe <= '0;
      r_data     <= '0;
    end else begin
      r_vld_pipe[1] <= i_rd;
      if (i_rd) r_data[1] <= i_data;
      for (int s = 2; s <= STAGES; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        if (r_vld_pipe[s-1]) r_data[s] <= r_data[s-1];
      end
    end
  end

  assign o_dout = r_data[STAGES];
  assign o_vld  = r_vld_pipe[STAGES];
endmodule

module dsp_dpram_ctl #(
  parameter int          DW       = 16,
  parameter int          AW       = 11,
  parameter bit          OUT_REG  = 1,
  parameter bit          RDW_MODE = 0,
  parameter bit          INIT_CLR = 1,
  parameter logic [DW-1:0] CLR_VAL = '0
)(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr_req,
  output logic         o_busy,
  dsp_dpram_if.slave   a,
  dsp_dpram_if.slave   b
);
  localparam int NP = 2;
  localparam int NB = DW / 8;

  // Reset holds the sequencer; release lands directly in CLEAR or IDLE so
  // busy covers exactly 2**AW cycles.
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                r_state, w_state_nxt;
  logic [AW-1:0]         r_clr_cnt, w_clr_cnt_nxt;
  logic [NP-1:0]         w_en, w_we, w_acc, w_rd, w_vld;
  logic [NP-1:0][NB-1:0] w_be;
  logic [NP-1:0][AW-1:0] w_addr;
  logic [NP-1:0][DW-1:0] w_din, w_rdata, w_dout;
  logic [DW-1:0]         r_mem [2**AW];

  assign w_en   = {b.en,   a.en};
  assign w_we   = {b.we,   a.we};
  assign w_be   = {b.be,   a.be};
  assign w_addr = {b.addr, a.addr};
  assign w_din  = {b.din,  a.din};
  assign a.dout = w_dout[0];
  assign a.vld  = w_vld[0];
  assign b.dout = w_dout[1];
  assign b.vld  = w_vld[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= INIT_CLR ? ST_CLEAR : ST_IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      ST_IDLE: if (i_clr_req) begin
        w_state_nxt   = ST_CLEAR;
        w_clr_cnt_nxt = '0;
      end
      ST_CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (r_clr_cnt == '1) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy = (r_state == ST_CLEAR);
  assign w_acc  = w_en & {NP{r_state == ST_IDLE}};
  assign w_rd   = w_acc & ~w_we;

  // Port B is applied first so port A overrides it on shared enabled bytes.
  always_ff @(posedge i_clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_cnt] <= CLR_VAL;
    end else begin
      for (int p = NP-1; p >= 0; p--)
        if (w_acc[p] && w_we[p])
          for (int i = 0; i < NB; i++)
            if (w_be[p][i]) r_mem[w_addr[p]][i*8 +: 8] <= w_din[p][i*8 +: 8];
    end
  end

  for (genvar g = 0; g < NP; g++) begin : g_port
    localparam int OTH = NP - 1 - g;
    logic [DW-1:0] w_merged;

    // Write-through: overlay the other port's enabled bytes on the stored word.
    always_comb begin
      w_merged = r_mem[w_addr[g]];
      if (RDW_MODE && w_acc[OTH] && w_we[OTH] && (w_addr[OTH] == w_addr[g]))
        for (int i = 0; i < NB; i++)
          if (w_be[OTH][i]) w_merged[i*8 +: 8] = w_din[OTH][i*8 +: 8];
    end
    assign w_rdata[g] = w_merged;
  end

  dsp_dpram_rdport #(.DW(DW), .OUT_REG(OUT_REG)) u_rd [NP-1:0] (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_rd    (w_rd),
    .i_data  (w_rdata),
    .o_dout  (w_dout),
    .o_vld   (w_vld)
  );
endmodule

// File: tb/tb_dsp_dpram_ctl.sv
// Directed bench: dut0 = OUT_REG 1 / old-data RDW, dut1 = OUT_REG 0 / write-through,
// both AW=4 with CLR_VAL A5A5 and driven by identical stimulus.
module tb_dsp_dpram_ctl;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam logic [15:0] CV = 16'hA5A5;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clr_req = 1'b0;
  logic busy0, busy1;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  dsp_dpram_if #(.DW(DW), .AW(AW)) a0 ();
  dsp_dpram_if #(.DW(DW), .AW(AW)) b0 ();
  dsp_dpram_if #(.DW(DW), .AW(AW)) a1 ();
  dsp_dpram_if #(.DW(DW), .AW(AW)) b1 ();

  assign a1.en = a0.en;  assign a1.we = a0.we;  assign a1.be = a0.be;
  assign a1.addr = a0.addr;  assign a1.din = a0.din;
  assign b1.en = b0.en;  assign b1.we = b0.we;  assign b1.be = b0.be;
  assign b1.addr = b0.addr;  assign b1.din = b0.din;

  dsp_dpram_ctl #(.DW(DW), .AW(AW), .OUT_REG(1), .RDW_MODE(0), .INIT_CLR(1), .CLR_VAL(CV)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr_req(clr_req), .o_busy(busy0), .a(a0), .b(b0));
  dsp_dpram_ctl #(.DW(DW), .AW(AW), .OUT_REG(0), .RDW_MODE(1), .INIT_CLR(1), .CLR_VAL(CV)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_clr_req(clr_req), .o_busy(busy1), .a(a1), .b(b1));

  task automatic set_a(input logic en, we, input logic [1:0] be, input logic [3:0] ad, input logic [15:0] d);
    a0.en = en; a0.we = we; a0.be = be; a0.addr = ad; a0.din = d;
  endtask

  task automatic set_b(input logic en, we, input logic [1:0] be, input logic [3:0] ad, input logic [15:0] d);
    b0.en = en; b0.we = we; b0.be = be; b0.addr = ad; b0.din = d;
  endtask

  task automatic test_reset();
    int cnt;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy0, busy1, a0.vld, b0.vld, a1.vld, b1.vld} !== 6'b110000) begin
      fails++; $display("FAIL reset_ctl got %b exp 110000", {busy0, busy1, a0.vld, b0.vld, a1.vld, b1.vld});
    end
    checks++;
    if ({a0.dout, b0.dout, a1.dout, b1.dout} !== 64'h0) begin
      fails++; $display("FAIL reset_dout got %h exp 0", {a0.dout, b0.dout, a1.dout, b1.dout});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (busy0 && cnt < 100) begin cnt++; @(negedge clk); end
    checks++;
    if (cnt != 16 || busy1 !== 1'b0) begin
      fails++; $display("FAIL init_busy_len got %0d busy1=%b exp 16 busy1=0", cnt, busy1);
    end
    for (int i = 0; i < 18; i++) begin
      if (i >= 1 && i <= 16) begin
        checks++;
        if (a1.vld !== 1'b1 || a1.dout !== CV) begin
          fails++; $display("FAIL init_rd1 addr %0d got vld=%b %h exp 1 %h", i-1, a1.vld, a1.dout, CV);
        end
      end
      if (i >= 2) begin
        checks++;
        if (a0.vld !== 1'b1 || a0.dout !== CV) begin
          fails++; $display("FAIL init_rd0 addr %0d got vld=%b %h exp 1 %h", i-2, a0.vld, a0.dout, CV);
        end
      end
      if (i < 16) set_a(1, 0, 2'b00, 4'(i), 16'h0); else set_a(0, 0, 2'b00, 4'h0, 16'h0);
      @(negedge clk);
    end
  endtask

  task automatic test_byte_write();
    set_a(1, 1, 2'b01, 4'd3, 16'h1234);
    @(negedge clk);
    set_a(0, 0, 2'b00, 4'd0, 16'h0);
    checks++;
    if (a0.vld !== 1'b0 || a1.vld !== 1'b0 || a0.dout !== CV || a1.dout !== CV) begin
      fails++; $display("FAIL wr_novld got vld=%b%b dout=%h/%h exp 00 %h", a0.vld, a1.vld, a0.dout, a1.dout, CV);
    end
    @(negedge clk);
    checks++;
    if (a0.vld !== 1'b0 || a0.dout !== CV) begin
      fails++; $display("FAIL wr_hold got vld=%b dout=%h exp 0 %h", a0.vld, a0.dout, CV);
    end
    set_a(1, 0, 2'b00, 4'd3, 16'h0);
    @(negedge clk);
    set_a(0, 0, 2'b00, 4'd0, 16'h0);
    checks++;
    if (a1.vld !== 1'b1 || a1.dout !== 16'hA534 || a0.vld !== 1'b0) begin
      fails++; $display("FAIL be_rd_lat1 got vld1=%b %h vld0=%b exp 1 a534 0", a1.vld, a1.dout, a0.vld);
    end
    @(negedge clk);
    checks++;
    if (a0.vld !== 1'b1 || a0.dout !== 16'hA534) begin
      fails++; $display("FAIL be_rd_lat2 got vld=%b %h exp 1 a534", a0.vld, a0.dout);
    end
  endtask

  task automatic test_ww_collision();
    set_a(1, 1, 2'b01, 4'd5, 16'h00FF);
    set_b(1, 1, 2'b11, 4'd5, 16'hAB00);
    @(negedge clk);
    set_a(1, 0, 2'b00, 4'd5, 16'h0);
    set_b(0, 0, 2'b00, 4'd0, 16'h0);
    @(negedge clk);
    set_a(0, 0, 2'b00, 4'd0, 16'h0);
    checks++;
    if (a1.vld !== 1'b1 || a1.dout !== 16'hABFF) begin
      fails++; $display("FAIL ww_coll1 got vld=%b %h exp 1 abff", a1.vld, a1.dout);
    end
    @(negedge clk);
    checks++;
    if (a0.vld !== 1'b1 || a0.dout !== 16'hABFF) begin
      fails++; $display("FAIL ww_coll0 got vld=%b %h exp 1 abff", a0.vld, a0.dout);
    end
  endtask

  task automatic test_rdw();
    set_a(1, 1, 2'b11, 4'd7, 16'hCAFE);
    @(negedge clk);
    set_a(1, 1, 2'b11, 4'd7, 16'hBEEF);
    set_b(1, 0, 2'b00, 4'd7, 16'h0);
    @(negedge clk);
    set_a(0, 0, 2'b00, 4'd0, 16'h0);
    set_b(0, 0, 2'b00, 4'd0, 16'h0);
    checks++;
    if (b1.vld !== 1'b1 || b1.dout !== 16'hBEEF || b0.vld !== 1'b0) begin
      fails++; $display("FAIL rdw_new got vld=%b %h vld0=%b exp 1 beef 0", b1.vld, b1.dout, b0.vld);
    end
    @(negedge clk);
    checks++;
    if (b0.vld !== 1'b1 || b0.dout !== 16'hCAFE) begin
      fails++; $display("FAIL rdw_old got vld=%b %h exp 1 cafe", b0.vld, b0.dout);
    end
    set_a(1, 0, 2'b00, 4'd7, 16'h0);
    set_b(1, 0, 2'b00, 4'd7, 16'h0);
    @(negedge clk);
    set_a(0, 0, 2'b00, 4'd0, 16'h0);
    set_b(0, 0, 2'b00, 4'd0, 16'h0);
    checks++;
    if (a1.vld !== 1'b1 || b1.vld !== 1'b1 || a1.dout !== 16'hBEEF || b1.dout !== 16'hBEEF) begin
      fails++; $display("FAIL rr_same1 got %b%b %h/%h exp 11 beef", a1.vld, b1.vld, a1.dout, b1.dout);
    end
    @(negedge clk);
    checks++;
    if (a0.vld !== 1'b1 || b0.vld !== 1'b1 || a0.dout !== 16'hBEEF || b0.dout !== 16'hBEEF) begin
      fails++; $display("FAIL rr_same0 got %b%b %h/%h exp 11 beef", a0.vld, b0.vld, a0.dout, b0.dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ex [3];
    logic [3:0]  ad [3];
    ex = '{16'hA534, 16'hABFF, 16'hBEEF};
    ad = '{4'd3, 4'd5, 4'd7};
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (c >= 1 && c <= 3) begin
        if (a1.vld !== 1'b1 || a1.dout !== ex[c-1]) begin
          fails++; $display("FAIL b2b_1 c%0d got vld=%b %h exp 1 %h", c, a1.vld, a1.dout, ex[c-1]);
        end
      end else if (a1.vld !== 1'b0) begin
        fails++; $display("FAIL b2b_1 c%0d got vld=%b exp 0", c, a1.vld);
      end
      checks++;
      if (c >= 2 && c <= 4) begin
        if (a0.vld !== 1'b1 || a0.dout !== ex[c-2]) begin
          fails++; $display("FAIL b2b_0 c%0d got vld=%b %h exp 1 %h", c, a0.vld, a0.dout, ex[c-2]);
        end
      end else if (a0.vld !== 1'b0) begin
        fails++; $display("FAIL b2b_0 c%0d got vld=%b exp 0", c, a0.vld);
      end
      if (c < 3) set_a(1, 0, 2'b00, ad[c], 16'h0); else set_a(0, 0, 2'b00, 4'd0, 16'h0);
      @(negedge clk);
    end
  endtask

  task automatic test_clear();
    int k;
    set_a(1, 1, 2'b11, 4'd2, 16'h1111);
    @(negedge clk);
    clr_req = 1'b1;
    set_a(1, 0, 2'b00, 4'd3, 16'h0);
    @(negedge clk);
    clr_req = 1'b0;
    k = 0;
    while (busy0 && k < 100) begin
      k++;
      clr_req = (k == 5);
      checks++;
      if (k == 1) begin
        if (a1.vld !== 1'b1 || a1.dout !== 16'hA534) begin
          fails++; $display("FAIL clr_same_cyc1 got vld=%b %h exp 1 a534", a1.vld, a1.dout);
        end
      end else if (k == 2) begin
        if (a0.vld !== 1'b1 || a0.dout !== 16'hA534 || a1.vld !== 1'b0) begin
          fails++; $display("FAIL clr_same_cyc0 got vld=%b %h vld1=%b exp 1 a534 0", a0.vld, a0.dout, a1.vld);
        end
      end else if (a0.vld !== 1'b0 || a1.vld !== 1'b0) begin
        fails++; $display("FAIL busy_rd k%0d got vld=%b%b exp 00", k, a0.vld, a1.vld);
      end
      @(negedge clk);
    end
    clr_req = 1'b0;
    set_a(0, 0, 2'b00, 4'd0, 16'h0);
    checks++;
    if (k != 16 || busy1 !== 1'b0) begin
      fails++; $display("FAIL clr_busy_len got %0d busy1=%b exp 16 busy1=0", k, busy1);
    end
    for (int i = 0; i < 18; i++) begin
      if (i >= 1 && i <= 16) begin
        checks++;
        if (a1.vld !== 1'b1 || a1.dout !== CV) begin
          fails++; $display("FAIL clr_rd1 addr %0d got vld=%b %h exp 1 %h", i-1, a1.vld, a1.dout, CV);
        end
      end
      if (i >= 2) begin
        checks++;
        if (a0.vld !== 1'b1 || a0.dout !== CV) begin
          fails++; $display("FAIL clr_rd0 addr %0d got vld=%b %h exp 1 %h", i-2, a0.vld, a0.dout, CV);
        end
      end
      if (i < 16) set_a(1, 0, 2'b00, 4'(i), 16'h0); else set_a(0, 0, 2'b00, 4'h0, 16'h0);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    set_a(1, 1, 2'b11, 4'd12, 16'h1357);
    @(negedge clk);
    set_a(0, 0, 2'b00, 4'd0, 16'h0);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a0.dout, b0.dout, a1.dout, b1.dout} !== 64'h0 || {a0.vld, b0.vld, a1.vld, b1.vld} !== 4'h0) begin
      fails++; $display("FAIL mid_rst_out got %h vld=%b exp 0", {a0.dout, b0.dout, a1.dout, b1.dout},
                        {a0.vld, b0.vld, a1.vld, b1.vld});
    end
    checks++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1) begin
      fails++; $display("FAIL mid_rst_busy got %b%b exp 11", busy0, busy1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    while (busy0 && cnt < 100) begin cnt++; @(negedge clk); end
    checks++;
    if (cnt != 16) begin
      fails++; $display("FAIL mid_rst_busy_len got %0d exp 16", cnt);
    end
    set_b(1, 0, 2'b00, 4'd12, 16'h0);
    @(negedge clk);
    set_b(0, 0, 2'b00, 4'd0, 16'h0);
    checks++;
    if (b1.vld !== 1'b1 || b1.dout !== CV) begin
      fails++; $display("FAIL mid_rst_rd1 got vld=%b %h exp 1 %h", b1.vld, b1.dout, CV);
    end
    @(negedge clk);
    checks++;
    if (b0.vld !== 1'b1 || b0.dout !== CV) begin
      fails++; $display("FAIL mid_rst_rd0 got vld=%b %h exp 1 %h", b0.vld, b0.dout, CV);
    end
  endtask

  initial begin
    set_a(0, 0, 2'b00, 4'd0, 16'h0);
    set_b(0, 0, 2'b00, 4'd0, 16'h0);
    test_reset();
    test_byte_write();
    test_ww_collision();
    test_rdw();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
